// File: rtl/audio_sample_fifo_pkg.sv
// Shared types and helpers for the parametrised audio sample FIFO.
package audio_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

  // Depth must be a power of two so the pointers can wrap by plain overflow.
  function automatic bit depth_ok(input int depth);
    return (depth >= 32'sd4) && ((depth & (depth - 32'sd1)) == 32'sd0);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full: 1'b0, empty: 1'b1, almost_full: 1'b0,
    almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
  };

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Producer/consumer bus of the audio sample FIFO; master drives requests, slave is the FIFO.
interface audio_sample_fifo_if
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 128
);
  localparam int LW = clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output wr_en, din, rd_en, err_clr,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, err_clr,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/audio_sample_fifo_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (read-first).
module fifo_sdp_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port; output register holds its value when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end
endmodule

// File: rtl/audio_sample_fifo.sv
// Parametrised synchronous sample FIFO with exact level, thresholds and sticky errors.
// Define AUDIO_FIFO_FWFT_EN for first-word-fall-through mode.
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 128,
  parameter int AFULL_TH  = 112,
  parameter int AEMPTY_TH = 16
) (
  input logic                clk,
  input logic                rst,
  audio_sample_fifo_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_TH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("audio_sample_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     level_r, level_nxt_s;
  fifo_status_t      status_r, status_nxt_s;
  logic              rd_acc_s, wr_acc_s, ram_we_s, ram_re_s;
  logic [DATA_W-1:0] ram_q_s;

  assign rd_acc_s = bus.rd_en & ~status_r.empty;
  assign wr_acc_s = bus.wr_en & (~status_r.full | rd_acc_s);

`ifdef AUDIO_FIFO_FWFT_EN
  // The output register is an occupied entry; memory holds the rest.
  logic              out_free_s, mem_has_s, byp_sel_r;
  logic [LW-1:0]     mem_cnt_s;
  logic [DATA_W-1:0] byp_r;

  assign mem_cnt_s  = level_r - {{(LW-1){1'b0}}, ~status_r.empty};
  assign mem_has_s  = (mem_cnt_s != '0);
  assign out_free_s = status_r.empty | rd_acc_s;
  assign ram_re_s   = out_free_s & mem_has_s;
  assign ram_we_s   = wr_acc_s & ~(out_free_s & ~mem_has_s);

  // Bypass register: a write into an empty pipeline lands here directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_sel_r <= 1'b0;
      byp_r     <= '0;
    end else if (out_free_s) begin
      if (mem_has_s) begin
        byp_sel_r <= 1'b0;
      end else if (wr_acc_s) begin
        byp_sel_r <= 1'b1;
        byp_r     <= bus.din;
      end
    end
  end

  assign bus.dout       = byp_sel_r ? byp_r : ram_q_s;
  assign bus.dout_valid = ~status_r.empty;
`else
  logic dout_valid_r;

  assign ram_re_s = rd_acc_s;
  assign ram_we_s = wr_acc_s;

  // Read data is valid for exactly one cycle after an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= rd_acc_s;
    end
  end

  assign bus.dout       = ram_q_s;
  assign bus.dout_valid = dout_valid_r;
`endif

  fifo_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .waddr (wr_ptr_r),
    .wdata (bus.din),
    .re    (ram_re_s),
    .raddr (rd_ptr_r),
    .rdata (ram_q_s)
  );

  // Next occupancy from accepted transfers.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Flags come from the next level so they line up with level itself.
  always_comb begin
    status_nxt_s              = status_r;
    status_nxt_s.full         = (level_nxt_s == LVL_FULL);
    status_nxt_s.empty        = (level_nxt_s == '0);
    status_nxt_s.almost_full  = (level_nxt_s >= LVL_AF);
    status_nxt_s.almost_empty = (level_nxt_s <= LVL_AE);
    status_nxt_s.overflow     = (status_r.overflow & ~bus.err_clr) | (bus.wr_en & ~wr_acc_s);
    status_nxt_s.underflow    = (status_r.underflow & ~bus.err_clr) | (bus.rd_en & ~rd_acc_s);
  end

  // Pointer, level and status state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      status_r <= STATUS_RST;
    end else begin
      if (ram_we_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (ram_re_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r  <= level_nxt_s;
      status_r <= status_nxt_s;
    end
  end

  assign bus.level        = level_r;
  assign bus.full         = status_r.full;
  assign bus.empty        = status_r.empty;
  assign bus.almost_full  = status_r.almost_full;
  assign bus.almost_empty = status_r.almost_empty;
  assign bus.overflow     = status_r.overflow;
  assign bus.underflow    = status_r.underflow;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed self-checking bench for audio_sample_fifo (standard mode; FWFT when AUDIO_FIFO_FWFT_EN).
module tb_audio_sample_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  audio_sample_fifo_if #(.DATA_W(24), .DEPTH(128)) bus ();

  audio_sample_fifo #(.DATA_W(24), .DEPTH(128), .AFULL_TH(112), .AEMPTY_TH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, " level"}, 32'(bus.level), 32'd0);
    check_val({tag, " empty"}, 32'(bus.empty), 32'd1);
    check_val({tag, " full"}, 32'(bus.full), 32'd0);
    check_val({tag, " afull"}, 32'(bus.almost_full), 32'd0);
    check_val({tag, " aempty"}, 32'(bus.almost_empty), 32'd1);
    check_val({tag, " ovf"}, 32'(bus.overflow), 32'd0);
    check_val({tag, " udf"}, 32'(bus.underflow), 32'd0);
    check_val({tag, " dout"}, 32'(bus.dout), 32'd0);
    check_val({tag, " dvalid"}, 32'(bus.dout_valid), 32'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = 24'd0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

`ifdef AUDIO_FIFO_FWFT_EN
    bus.wr_en = 1'b1; bus.din = 24'h123456;
    step();
    bus.wr_en = 1'b0;
    check_val("fwft first dout", 32'(bus.dout), 32'h123456);
    check_val("fwft first valid", 32'(bus.dout_valid), 32'd1);
    check_val("fwft first level", 32'(bus.level), 32'd1);
    bus.wr_en = 1'b1; bus.din = 24'h000111; step();
    bus.din = 24'h000222; step();
    bus.wr_en = 1'b0;
    check_val("fwft level3", 32'(bus.level), 32'd3);
    check_val("fwft head held", 32'(bus.dout), 32'h123456);
    bus.rd_en = 1'b1; step();
    check_val("fwft pop1 dout", 32'(bus.dout), 32'h000111);
    check_val("fwft pop1 level", 32'(bus.level), 32'd2);
    step();
    check_val("fwft pop2 dout", 32'(bus.dout), 32'h000222);
    step();
    check_val("fwft drained empty", 32'(bus.empty), 32'd1);
    check_val("fwft drained valid", 32'(bus.dout_valid), 32'd0);
    step();
    check_val("fwft udf", 32'(bus.underflow), 32'd1);
    bus.wr_en = 1'b1; bus.din = 24'hABCDEF; step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check_val("fwft rw-empty level", 32'(bus.level), 32'd1);
    check_val("fwft rw-empty dout", 32'(bus.dout), 32'hABCDEF);
    check_val("fwft rw-empty valid", 32'(bus.dout_valid), 32'd1);
`else
    // Fill to full, tracking thresholds on every write.
    for (int i = 1; i <= 128; i++) begin
      bus.wr_en = 1'b1; bus.din = 24'(i);
      step();
      check_val($sformatf("fill level %0d", i), 32'(bus.level), 32'(i));
      check_val($sformatf("fill afull %0d", i), 32'(bus.almost_full), (i >= 112) ? 32'd1 : 32'd0);
      check_val($sformatf("fill aempty %0d", i), 32'(bus.almost_empty), (i <= 16) ? 32'd1 : 32'd0);
      check_val($sformatf("fill full %0d", i), 32'(bus.full), (i == 128) ? 32'd1 : 32'd0);
    end
    check_val("pre-ovf flag", 32'(bus.overflow), 32'd0);
    bus.din = 24'h000999;
    step();
    bus.wr_en = 1'b0;
    check_val("ovf flag", 32'(bus.overflow), 32'd1);
    check_val("ovf level", 32'(bus.level), 32'd128);

    // Drain in order.
    for (int i = 1; i <= 128; i++) begin
      bus.rd_en = 1'b1;
      step();
      check_val($sformatf("drain dout %0d", i), 32'(bus.dout), 32'(i));
      check_val($sformatf("drain valid %0d", i), 32'(bus.dout_valid), 32'd1);
      check_val($sformatf("drain level %0d", i), 32'(bus.level), 32'(128 - i));
    end
    check_val("drain empty", 32'(bus.empty), 32'd1);
    check_val("drain ovf kept", 32'(bus.overflow), 32'd1);
    step();
    bus.rd_en = 1'b0;
    check_val("udf flag", 32'(bus.underflow), 32'd1);
    check_val("udf no valid", 32'(bus.dout_valid), 32'd0);

    // Error clear alone, then clear racing a new refused read.
    bus.err_clr = 1'b1; step();
    check_val("clr ovf", 32'(bus.overflow), 32'd0);
    check_val("clr udf", 32'(bus.underflow), 32'd0);
    bus.rd_en = 1'b1; step();
    bus.rd_en = 1'b0;
    check_val("clr+udf udf", 32'(bus.underflow), 32'd1);
    check_val("clr+udf ovf", 32'(bus.overflow), 32'd0);
    step();
    bus.err_clr = 1'b0;
    check_val("clr again udf", 32'(bus.underflow), 32'd0);

    // Full with simultaneous read/write, then drain across the pointer wrap.
    for (int j = 0; j < 128; j++) begin
      bus.wr_en = 1'b1; bus.din = 24'(32'h200 + j);
      step();
    end
    check_val("refill full", 32'(bus.full), 32'd1);
    for (int k = 0; k < 10; k++) begin
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 24'(32'h280 + k);
      step();
      check_val($sformatf("rw-full dout %0d", k), 32'(bus.dout), 32'(32'h200 + k));
      check_val($sformatf("rw-full level %0d", k), 32'(bus.level), 32'd128);
      check_val($sformatf("rw-full ovf %0d", k), 32'(bus.overflow), 32'd0);
    end
    bus.wr_en = 1'b0;
    for (int m = 10; m < 138; m++) begin
      bus.rd_en = 1'b1;
      step();
      check_val($sformatf("wrap dout %0d", m), 32'(bus.dout), 32'(32'h200 + m));
    end
    check_val("wrap empty", 32'(bus.empty), 32'd1);
    check_val("wrap udf", 32'(bus.underflow), 32'd0);

    // Simultaneous read/write while empty.
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 24'hABCDEF;
    step();
    bus.wr_en = 1'b0;
    check_val("rw-empty level", 32'(bus.level), 32'd1);
    check_val("rw-empty udf", 32'(bus.underflow), 32'd1);
    check_val("rw-empty valid", 32'(bus.dout_valid), 32'd0);
    step();
    bus.rd_en = 1'b0;
    check_val("rw-empty dout", 32'(bus.dout), 32'hABCDEF);
    check_val("rw-empty rd valid", 32'(bus.dout_valid), 32'd1);

    // Asynchronous reset with level 50 and a live read word.
    for (int i = 0; i < 51; i++) begin
      bus.wr_en = 1'b1; bus.din = 24'(32'h300 + i);
      step();
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check_val("pre-rst level", 32'(bus.level), 32'd50);
    check_val("pre-rst dout", 32'(bus.dout), 32'h300);
    #2 rst = 1'b1;
    #1;
    check_reset_state("async rst");
    step();
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.din = 24'h000777; step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1; step();
    bus.rd_en = 1'b0;
    check_val("post-rst dout", 32'(bus.dout), 32'h777);
    check_val("post-rst level", 32'(bus.level), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
